// File: rtl/sap_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap_controller_sequencer
//
// Ring-counter controller/sequencer for the SAP CPU. Walks INIT -> T1..T6 and
// produces the control word for every bus-attached block in each T-state.
// T1..T3 fetch the instruction into IR. T4..T6 execute it, decoded from the
// IR opcode nibble. HLT parks the machine in a sticky HALT state that only
// clr can leave.
//
// Ports:
//   clk      - system clock, all state changes on its rising edge
//   clr      - asynchronous active-high reset, forces INIT
//   run      - advance enable; while low the current T-state is held
//   opcode   - IR upper nibble, decoded combinationally during T4..T6
//   pc_en    - program counter output/count enable
//   pc_inc   - program counter increment
//   pc_clr   - program counter clear (only acts together with pc_en)
//   mar_ld   - MAR load from bus
//   ram_en   - RAM drives bus
//   ir_ld    - IR load from bus
//   ir_en    - IR operand nibble drives bus
//   acc_ld   - accumulator load from bus
//   acc_en   - accumulator drives bus
//   b_ld     - B register load from bus
//   alu_en   - ALU result drives bus
//   alu_sub  - ALU subtract select (0 = add)
//   out_ld   - output register load
//   t_state  - one-hot T1..T6 (bit0 = T1), zero in INIT and HALT
//   halted   - high while in HALT
// -----------------------------------------------------------------------------
module sap_controller_sequencer #(
    parameter logic [3:0] OPC_LDA = 4'h0,
    parameter logic [3:0] OPC_ADD = 4'h1,
    parameter logic [3:0] OPC_SUB = 4'h2,
    parameter logic [3:0] OPC_OUT = 4'hE,
    parameter logic [3:0] OPC_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       pc_clr,
    output logic       mar_ld,
    output logic       ram_en,
    output logic       ir_ld,
    output logic       ir_en,
    output logic       acc_ld,
    output logic       acc_en,
    output logic       b_ld,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       out_ld,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_INIT,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;

    // Opcode decode. Anything that is not one of the five known opcodes
    // falls through with every flag low and so behaves as a NOP.
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic is_mem_op;

    always_comb begin
        is_lda    = (opcode == OPC_LDA);
        is_add    = (opcode == OPC_ADD);
        is_sub    = (opcode == OPC_SUB);
        is_out    = (opcode == OPC_OUT);
        is_hlt    = (opcode == OPC_HLT);
        is_mem_op = is_lda | is_add | is_sub;
    end

    // State register. clr wins over everything, including HALT.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The ring only moves while run is high. HALT ignores
    // run entirely so the machine stays parked until clr.
    always_comb begin
        state_next = state;
        if (run) begin
            case (state)
                S_INIT:  state_next = S_T1;
                S_T1:    state_next = S_T2;
                S_T2:    state_next = S_T3;
                S_T3:    state_next = S_T4;
                S_T4:    state_next = is_hlt ? S_HALT : S_T5;
                S_T5:    state_next = S_T6;
                S_T6:    state_next = S_T1;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_INIT;
            endcase
        end
    end

    // Control word. It is purely a function of the current state, plus the
    // opcode in T4..T6, so a held state keeps re-issuing the same controls.
    // At most one bus driver (pc_en, ram_en, ir_en, acc_en, alu_en) is active
    // in any state. INIT holds pc_en together with pc_clr because the PC only
    // honours a clear while it is enabled; its bus value is then zero.
    always_comb begin
        pc_en   = 1'b0;
        pc_inc  = 1'b0;
        pc_clr  = 1'b0;
        mar_ld  = 1'b0;
        ram_en  = 1'b0;
        ir_ld   = 1'b0;
        ir_en   = 1'b0;
        acc_ld  = 1'b0;
        acc_en  = 1'b0;
        b_ld    = 1'b0;
        alu_en  = 1'b0;
        alu_sub = 1'b0;
        out_ld  = 1'b0;
        t_state = 6'b000000;
        halted  = 1'b0;

        case (state)
            S_INIT: begin
                pc_en  = 1'b1;
                pc_clr = 1'b1;
            end

            // Fetch: address out of PC into MAR.
            S_T1: begin
                t_state = 6'b000001;
                pc_en   = 1'b1;
                mar_ld  = 1'b1;
            end

            // Fetch: step the PC past the instruction just addressed.
            S_T2: begin
                t_state = 6'b000010;
                pc_en   = 1'b1;
                pc_inc  = 1'b1;
            end

            // Fetch: instruction from RAM into IR.
            S_T3: begin
                t_state = 6'b000100;
                ram_en  = 1'b1;
                ir_ld   = 1'b1;
            end

            // Execute 1: memory ops put their operand address into MAR,
            // OUT copies the accumulator to the output register.
            S_T4: begin
                t_state = 6'b001000;
                if (is_mem_op) begin
                    ir_en  = 1'b1;
                    mar_ld = 1'b1;
                end else if (is_out) begin
                    acc_en = 1'b1;
                    out_ld = 1'b1;
                end
            end

            // Execute 2: the memory operand goes to A for LDA, to B for
            // ADD/SUB so the ALU can combine it with A in the next state.
            S_T5: begin
                t_state = 6'b010000;
                if (is_lda) begin
                    ram_en = 1'b1;
                    acc_ld = 1'b1;
                end else if (is_add || is_sub) begin
                    ram_en = 1'b1;
                    b_ld   = 1'b1;
                end
            end

            // Execute 3: ALU result written back into the accumulator.
            S_T6: begin
                t_state = 6'b100000;
                if (is_add) begin
                    alu_en = 1'b1;
                    acc_ld = 1'b1;
                end else if (is_sub) begin
                    alu_en  = 1'b1;
                    alu_sub = 1'b1;
                    acc_ld  = 1'b1;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                t_state = 6'b000000;
            end
        endcase
    end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_controller_sequencer
//
// Directed bench for the SAP controller/sequencer. The stimulus process drives
// run/opcode/clr and pushes the hand-computed control word expected for each
// cycle into a scoreboard queue. A separate monitor pops and compares on every
// falling edge, or immediately when an asynchronous clear is signalled, and
// also checks that no two bus drivers are ever active together.
// -----------------------------------------------------------------------------
module tb_sap_controller_sequencer;

    logic       clk;
    logic       clr;
    logic       run;
    logic [3:0] opcode;
    logic       pc_en;
    logic       pc_inc;
    logic       pc_clr;
    logic       mar_ld;
    logic       ram_en;
    logic       ir_ld;
    logic       ir_en;
    logic       acc_ld;
    logic       acc_en;
    logic       b_ld;
    logic       alu_en;
    logic       alu_sub;
    logic       out_ld;
    logic [5:0] t_state;
    logic       halted;

    sap_controller_sequencer dut (
        .clk     (clk),
        .clr     (clr),
        .run     (run),
        .opcode  (opcode),
        .pc_en   (pc_en),
        .pc_inc  (pc_inc),
        .pc_clr  (pc_clr),
        .mar_ld  (mar_ld),
        .ram_en  (ram_en),
        .ir_ld   (ir_ld),
        .ir_en   (ir_en),
        .acc_ld  (acc_ld),
        .acc_en  (acc_en),
        .b_ld    (b_ld),
        .alu_en  (alu_en),
        .alu_sub (alu_sub),
        .out_ld  (out_ld),
        .t_state (t_state),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bits in the order they are packed into an expected word.
    localparam logic [12:0] C_PC_EN   = 13'h1000;
    localparam logic [12:0] C_PC_INC  = 13'h0800;
    localparam logic [12:0] C_PC_CLR  = 13'h0400;
    localparam logic [12:0] C_MAR_LD  = 13'h0200;
    localparam logic [12:0] C_RAM_EN  = 13'h0100;
    localparam logic [12:0] C_IR_LD   = 13'h0080;
    localparam logic [12:0] C_IR_EN   = 13'h0040;
    localparam logic [12:0] C_ACC_LD  = 13'h0020;
    localparam logic [12:0] C_ACC_EN  = 13'h0010;
    localparam logic [12:0] C_B_LD    = 13'h0008;
    localparam logic [12:0] C_ALU_EN  = 13'h0004;
    localparam logic [12:0] C_ALU_SUB = 13'h0002;
    localparam logic [12:0] C_OUT_LD  = 13'h0001;

    localparam logic [5:0] T0 = 6'b000000;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [19:0] M_ALL   = 20'hFFFFF;
    localparam logic [19:0] M_TSTAT = {6'h3F, 1'b1, 13'h0000};

    // Packs {t_state, halted, controls} into one comparable word.
    function automatic logic [19:0] w(input logic [5:0] t, input logic h, input logic [12:0] c);
        return {t, h, c};
    endfunction

    localparam logic [19:0] W_INIT = {T0, 1'b0, C_PC_EN | C_PC_CLR};
    localparam logic [19:0] W_F1   = {T1, 1'b0, C_PC_EN | C_MAR_LD};
    localparam logic [19:0] W_F2   = {T2, 1'b0, C_PC_EN | C_PC_INC};
    localparam logic [19:0] W_F3   = {T3, 1'b0, C_RAM_EN | C_IR_LD};
    localparam logic [19:0] W_HALT = {T0, 1'b1, 13'h0000};

    typedef struct {
        logic [19:0] exp;
        logic [19:0] mask;
        int          id;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      sample_ev;
    int        step_id = 0;
    int        total   = 0;
    int        bad     = 0;

    task automatic push_exp(input logic [19:0] e, input logic [19:0] m);
        sb_entry_t s;
        s.exp  = e;
        s.mask = m;
        s.id   = step_id;
        step_id++;
        sb.push_back(s);
    endtask

    // Inputs change just after a falling edge so the previous cycle has been
    // sampled; the expectation describes the state after the next rising edge.
    task automatic apply_stimulus(input logic r, input logic [3:0] op,
                                  input logic [19:0] e, input logic [19:0] m);
        @(negedge clk);
        #1;
        run    = r;
        opcode = op;
        @(posedge clk);
        #1;
        push_exp(e, m);
    endtask

    task automatic fetch(input logic [3:0] op);
        apply_stimulus(1'b1, op, W_F1, M_ALL);
        apply_stimulus(1'b1, op, W_F2, M_ALL);
        apply_stimulus(1'b1, op, W_F3, M_ALL);
    endtask

    // Raises clr between clock edges and has it checked straight away, then
    // keeps it high across one rising edge before releasing it with run low.
    task automatic clear_pulse();
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        push_exp(W_INIT, M_ALL);
        ->sample_ev;
        @(posedge clk);
        #1;
        push_exp(W_INIT, M_ALL);
        @(negedge clk);
        #1;
        clr = 1'b0;
        run = 1'b0;
    endtask

    // Compares one scoreboard entry against the live outputs.
    task automatic check_output(input sb_entry_t s);
        logic [19:0] act;
        int          drivers;
        act = {t_state, halted, pc_en, pc_inc, pc_clr, mar_ld, ram_en, ir_ld,
               ir_en, acc_ld, acc_en, b_ld, alu_en, alu_sub, out_ld};
        total++;
        if ((act & s.mask) !== (s.exp & s.mask)) begin
            bad++;
            $display("[TB] FAIL step%0d: got t=%b h=%b ctl=%b want t=%b h=%b ctl=%b (mask %h)",
                     s.id, act[19:14], act[13], act[12:0],
                     s.exp[19:14], s.exp[13], s.exp[12:0], s.mask);
        end
        drivers = int'(pc_en) + int'(ram_en) + int'(ir_en) + int'(acc_en) + int'(alu_en);
        total++;
        if (drivers > 1) begin
            bad++;
            $display("[TB] FAIL bus_onehot step%0d: got %0d drivers want at most 1", s.id, drivers);
        end
    endtask

    // Monitor: one pop per falling edge, or per asynchronous sample request.
    initial begin
        sb_entry_t s;
        forever begin
            @(negedge clk or sample_ev);
            if (sb.size() > 0) begin
                s = sb.pop_front();
                check_output(s);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Random execute opcodes; 4'hF is left out so the stream never halts.
    logic [3:0] op_tbl [8];

    initial begin
        logic [3:0] op;
        logic [5:0] tv;

        op_tbl[0] = 4'h0; op_tbl[1] = 4'h1; op_tbl[2] = 4'h2; op_tbl[3] = 4'hE;
        op_tbl[4] = 4'h7; op_tbl[5] = 4'h3; op_tbl[6] = 4'h9; op_tbl[7] = 4'hC;

        clr    = 1'b1;
        run    = 1'b0;
        opcode = 4'h0;
        $display("[TB] starting sequencer test");

        // Reset, then release and start running.
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        push_exp(W_INIT, M_ALL);

        // LDA
        fetch(4'h0);
        apply_stimulus(1'b1, 4'h0, w(T4, 1'b0, C_IR_EN | C_MAR_LD), M_ALL);
        apply_stimulus(1'b1, 4'h0, w(T5, 1'b0, C_RAM_EN | C_ACC_LD), M_ALL);
        apply_stimulus(1'b1, 4'h0, w(T6, 1'b0, 13'h0000), M_ALL);

        // ADD
        fetch(4'h1);
        apply_stimulus(1'b1, 4'h1, w(T4, 1'b0, C_IR_EN | C_MAR_LD), M_ALL);
        apply_stimulus(1'b1, 4'h1, w(T5, 1'b0, C_RAM_EN | C_B_LD), M_ALL);
        apply_stimulus(1'b1, 4'h1, w(T6, 1'b0, C_ALU_EN | C_ACC_LD), M_ALL);

        // SUB
        fetch(4'h2);
        apply_stimulus(1'b1, 4'h2, w(T4, 1'b0, C_IR_EN | C_MAR_LD), M_ALL);
        apply_stimulus(1'b1, 4'h2, w(T5, 1'b0, C_RAM_EN | C_B_LD), M_ALL);
        apply_stimulus(1'b1, 4'h2, w(T6, 1'b0, C_ALU_EN | C_ALU_SUB | C_ACC_LD), M_ALL);

        // OUT with run dropped for four cycles while in T3
        fetch(4'hE);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 4'hE, W_F3, M_ALL);
        end
        apply_stimulus(1'b1, 4'hE, w(T4, 1'b0, C_ACC_EN | C_OUT_LD), M_ALL);
        apply_stimulus(1'b1, 4'hE, w(T5, 1'b0, 13'h0000), M_ALL);
        apply_stimulus(1'b1, 4'hE, w(T6, 1'b0, 13'h0000), M_ALL);

        // Unknown opcode 7 runs as a NOP
        fetch(4'h7);
        apply_stimulus(1'b1, 4'h7, w(T4, 1'b0, 13'h0000), M_ALL);
        apply_stimulus(1'b1, 4'h7, w(T5, 1'b0, 13'h0000), M_ALL);
        apply_stimulus(1'b1, 4'h7, w(T6, 1'b0, 13'h0000), M_ALL);

        // LDA interrupted by clr in T5
        fetch(4'h0);
        apply_stimulus(1'b1, 4'h0, w(T4, 1'b0, C_IR_EN | C_MAR_LD), M_ALL);
        apply_stimulus(1'b1, 4'h0, w(T5, 1'b0, C_RAM_EN | C_ACC_LD), M_ALL);
        clear_pulse();
        apply_stimulus(1'b0, 4'h0, W_INIT, M_ALL);

        // Random opcode stream: T-state ring plus bus-driver check each cycle
        for (int n = 0; n < 12; n++) begin
            op = (n == 0) ? 4'h7 : op_tbl[$urandom_range(0, 7)];
            for (int p = 0; p < 6; p++) begin
                tv = T1 << p;
                apply_stimulus(1'b1, op, w(tv, 1'b0, 13'h0000), M_TSTAT);
            end
        end

        // HLT: T4 issues nothing, then HALT sticks with everything low
        fetch(4'hF);
        apply_stimulus(1'b1, 4'hF, w(T4, 1'b0, 13'h0000), M_ALL);
        for (int i = 0; i < 21; i++) begin
            apply_stimulus(1'b1, 4'hF, W_HALT, M_ALL);
        end

        // clr while halted, then restart from T1
        clear_pulse();
        apply_stimulus(1'b1, 4'h0, W_F1, M_ALL);
        apply_stimulus(1'b1, 4'h0, W_F2, M_ALL);

        // Let the monitor drain what is left, bounded
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
Ring-counter controller/sequencer for the SAP CPU. Generates the per-T-state control word that drives the program counter (pc_en/pc_inc/pc_clr), MAR, RAM, IR, accumulator, B register, ALU and output register. Sits upstream of the program counter and all bus-attached registers, and decodes the opcode nibble supplied by the instruction register. Executes fetch (T1-T3) and execute (T4-T6) for LDA/ADD/SUB/OUT/HLT.

Parameters:
OPC_LDA, 4'h0, opcode for load accumulator from memory
OPC_ADD, 4'h1, opcode for A <= A + mem
OPC_SUB, 4'h2, opcode for A <= A - mem
OPC_OUT, 4'hE, opcode for OUT <= A
OPC_HLT, 4'hF, opcode for halt

Ports:
clk  in  1  system clock; all state changes on posedge
clr  in  1  asynchronous, active-high reset
run  in  1  sequencer advance enable (single-step/free-run gate)
opcode  in  4  IR upper nibble; stable from T4 through T6
pc_en  out  1  program counter output/count enable
pc_inc  out  1  program counter increment
pc_clr  out  1  program counter clear (effective only with pc_en)
mar_ld  out  1  MAR load from bus
ram_en  out  1  RAM drives bus
ir_ld  out  1  IR load from bus
ir_en  out  1  IR operand nibble drives bus
acc_ld  out  1  accumulator load from bus
acc_en  out  1  accumulator drives bus
b_ld  out  1  B register load from bus
alu_en  out  1  ALU result drives bus
alu_sub  out  1  ALU subtract select (0 = add)
out_ld  out  1  output register load
t_state  out  6  one-hot T1..T6 (bit0 = T1); 0 in INIT/HALT
halted  out  1  high in HALT state

Behaviour:
- States: INIT, T1..T6, HALT. clr high -> async to INIT, halted=0.
- All outputs combinational from state (plus opcode in T4-T6); no output latency beyond state.
- Reset/INIT outputs: pc_en=1, pc_clr=1, all others 0, t_state=0. (The PC only clears when enabled, so INIT holds both high.)
- Transitions on posedge clk when run=1: INIT->T1, T1->T2, ..., T5->T6, T6->T1. If opcode==OPC_HLT in T4, T4->HALT. HALT is sticky until clr.
- run=0: state holds. Outputs still reflect the held state. Single-stepping repeats the state's controls each cycle; the bench keeps pc_inc states out of multi-cycle holds.
- Control word per state (unlisted = 0):
  T1: pc_en, mar_ld
  T2: pc_en, pc_inc
  T3: ram_en, ir_ld
  T4: LDA/ADD/SUB: ir_en, mar_ld. OUT: acc_en, out_ld. HLT/other: none.
  T5: LDA: ram_en, acc_ld. ADD/SUB: ram_en, b_ld. others: none.
  T6: ADD: alu_en, acc_ld. SUB: alu_en, alu_sub, acc_ld. others: none.
  HALT: all 0, halted=1.
- Unknown opcodes execute as NOP: T4-T6 with no controls, then T1.
- Invariant: at most one of {pc_en, ram_en, ir_en, acc_en, alu_en} is high in any state except INIT. In INIT only pc_en is high, and its bus output is 0 after clear.
- clr mid-instruction (any state, including HALT): immediate return to INIT. The next instruction starts from PC=0.
- Opcode is sampled combinationally each cycle of T4-T6. A change in opcode mid-execute changes the controls; IR stability is an upstream guarantee.

Test Plan:
- Reset: assert clr, release; run=1 -> cycle0 INIT (pc_en=pc_clr=1), cycle1 t_state=6'b000001 with pc_en=mar_ld=1, cycle2 pc_en=pc_inc=1, cycle3 ram_en=ir_ld=1.
- LDA (opcode=0): T4 ir_en+mar_ld, T5 ram_en+acc_ld, T6 no controls, next cycle T1. In a full system with RAM[0]=8'h09 and RAM[9]=8'h1C, A=8'h1C after T6.
- ADD/SUB: opcode=1 -> T6 alu_en=acc_ld=1, alu_sub=0. opcode=2 -> T6 alu_sub=1. In a full system with A=5 and B=3, ADD gives 8 and SUB gives 2.
- OUT then HLT: opcode=E gives T4 acc_en=out_ld=1. opcode=F at T4 -> next cycle halted=1, t_state=0, all controls 0 for 20 further cycles.
- run gating: drop run in T3 for 4 cycles -> t_state holds 6'b000100. Raise run -> T4 next edge.
- clr mid-T5 and while halted: async assert -> INIT outputs immediately, halted=0. Check the bus-driver one-hot invariant every cycle across a random opcode stream including 4'h7.
